stopwatch_ctrl: RTL

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

---
 rtl/stopwatch_ctrl_if.sv | 39 +++
 rtl/stopwatch_ctrl.sv | 107 ++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl_if.sv
// rtl/stopwatch_ctrl_if.sv - control/status bundle between the stopwatch controller and its counters/buttons
//
// Signals:
//   btn_start_stop  single-cycle start / pause / resume request
//   btn_clear       single-cycle clear request
//   mode_down       1 = countdown, 0 = count up (taken when a run starts)
//   digit_thr       per-digit threshold flags from the digit counters
//   digit_en        per-digit count enable
//   up_down         direction to all counters (1 = up)
//   counter_clr     one-cycle clear pulse to the counters
//   running, done   state flags
//   wrap            up-count rollover of the whole display
//   state           current controller state
// Modports: master = buttons/counters side, slave = controller.
interface stopwatch_ctrl_if #(
    parameter int NUM_DIGITS = 4
);
    logic                  btn_start_stop;
    logic                  btn_clear;
    logic                  mode_down;
    logic [NUM_DIGITS-1:0] digit_thr;
    logic [NUM_DIGITS-1:0] digit_en;
    logic                  up_down;
    logic                  counter_clr;
    logic                  running;
    logic                  done;
    logic                  wrap;
    logic [1:0]            state;

    modport master (
        output btn_start_stop, btn_clear, mode_down, digit_thr,
        input  digit_en, up_down, counter_clr, running, done, wrap, state
    );

    modport slave (
        input  btn_start_stop, btn_clear, mode_down, digit_thr,
        output digit_en, up_down, counter_clr, running, done, wrap, state
    );
endinterface

// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - stopwatch run/pause/countdown controller driving cascaded digit counters
//
// Parameters:
//   TICK_DIV    clk cycles per count tick (>= 2)
//   NUM_DIGITS  number of cascaded digit counters
// Ports:
//   clk   clock, rising edge
//   rst   asynchronous active-high reset
//   bus   stopwatch_ctrl_if.slave: button/mode/threshold inputs, enables/direction/clear/status outputs
module stopwatch_ctrl #(
    parameter int TICK_DIV   = 1000000,
    parameter int NUM_DIGITS = 4
) (
    input  logic              clk,
    input  logic              rst,
    stopwatch_ctrl_if.slave   bus
);
    localparam int            PW        = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic            mode_down_q, mode_down_d;
    logic            counter_clr_q;

    logic                  tick;
    logic                  thr_all;
    logic                  expire;
    logic [NUM_DIGITS-1:0] en;

    assign thr_all = &bus.digit_thr;
    assign tick    = (state_q == RUN) && (presc_q == PRESC_MAX);
    // Countdown has reached all zeros: this tick must not move any digit.
    assign expire  = tick && mode_down_q && thr_all;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            presc_q       <= '0;
            mode_down_q   <= 1'b0;
            counter_clr_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            presc_q       <= presc_d;
            mode_down_q   <= mode_down_d;
            counter_clr_q <= bus.btn_clear;
        end
    end

    always_comb begin
        state_d     = state_q;
        mode_down_d = mode_down_q;
        presc_d     = presc_q;

        if (bus.btn_clear) begin
            state_d = IDLE;
            presc_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.btn_start_stop) begin
                        mode_down_d = bus.mode_down;
                        // Countdown started from zero has nothing to count.
                        state_d = (bus.mode_down && thr_all) ? DONE : RUN;
                    end
                end
                RUN: begin
                    // Expiry beats a same-cycle pause so the run cannot stall at zero.
                    if (expire)
                        state_d = DONE;
                    else if (bus.btn_start_stop)
                        state_d = PAUSE;
                end
                PAUSE: begin
                    if (bus.btn_start_stop)
                        state_d = RUN;
                end
                default: ;
            endcase

            if (state_q == RUN)
                presc_d = tick ? '0 : presc_q + PW'(1);
        end
    end

    always_comb begin
        en    = '0;
        en[0] = tick && !expire;
        for (int i = 1; i < NUM_DIGITS; i++)
            en[i] = en[i-1] & bus.digit_thr[i-1];
    end

    assign bus.digit_en    = en;
    assign bus.up_down     = !mode_down_q;
    assign bus.counter_clr = counter_clr_q;
    assign bus.running     = (state_q == RUN);
    assign bus.done        = (state_q == DONE);
    assign bus.wrap        = !mode_down_q && tick && thr_all;
    assign bus.state       = state_q;
endmodule
